// File: rtl/ukf_input_loader.sv
// Streams a block of covariance words from on-chip memory into the UKF input FIFO,
// using a credit-limited skid buffer so memory reads never outrun downstream space.
module ukf_input_loader #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 128,
    parameter int READ_LATENCY = 1,
    parameter int BUF_DEPTH    = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    input  logic                ready_in,
    input  logic [DATA_W-1:0]   readdata,
    output logic [ADDR_W-1:0]   address,
    output logic                chipselect,
    output logic                clken,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                write,
    output logic                wr_enable,
    output logic [DATA_W-1:0]   write_data,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CR_W  = OCC_W + 1;

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, FLUSH} state_t;

    state_t                  state, state_next;
    logic [ADDR_W-1:0]       base_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        issued;
    logic [CNT_W-1:0]        sent;
    logic [READ_LATENCY-1:0] pipe;
    logic [DATA_W-1:0]       buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]        head, tail;
    logic [OCC_W-1:0]        occ;
    logic [OCC_W-1:0]        inflight;
    logic [CR_W-1:0]         credit_used;
    logic                    issue;
    logic [ADDR_W-1:0]       issue_addr;
    logic                    push, pop, flush_now;

    assign clken      = 1'b1;
    assign byteenable = '1;
    assign write      = 1'b0;

    // Reads still owed back by memory: the request on the bus plus the valid pipe.
    always_comb begin
        inflight = OCC_W'(chipselect);
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + OCC_W'(pipe[i]);
        end
        credit_used = CR_W'(inflight) + CR_W'(occ);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (word_count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_next = FLUSH;
                end else if (issued == count_q) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_next = FLUSH;
                end else if (sent == count_q) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            FLUSH: begin
                if (inflight == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The first read goes out straight from IDLE so chipselect rises the cycle after start.
    always_comb begin
        issue      = 1'b0;
        issue_addr = base_q + issued[ADDR_W-1:0];
        if (state == IDLE && start && word_count != '0) begin
            issue      = 1'b1;
            issue_addr = base_addr;
        end else if (state == ISSUE && !abort && issued < count_q &&
                     credit_used < CR_W'(BUF_DEPTH)) begin
            issue = 1'b1;
        end
    end

    assign flush_now = (state_next == FLUSH);
    assign push      = pipe[READ_LATENCY-1] && !flush_now;
    assign pop       = (state == ISSUE || state == DRAIN) && !abort &&
                       occ != '0 && ready_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            issued     <= '0;
            sent       <= '0;
            pipe       <= '0;
            head       <= '0;
            tail       <= '0;
            occ        <= '0;
            address    <= '0;
            chipselect <= 1'b0;
            wr_enable  <= 1'b0;
            write_data <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            chipselect <= issue;
            if (issue) begin
                address <= issue_addr;
            end

            if (state == IDLE && start) begin
                base_q  <= base_addr;
                count_q <= word_count;
                issued  <= CNT_W'(issue);
                sent    <= '0;
            end else if (issue) begin
                issued <= issued + CNT_W'(1);
            end

            pipe[0] <= chipselect;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end

            wr_enable <= pop;
            if (pop) begin
                write_data <= buf_mem[head];
                head       <= head + PTR_W'(1);
                sent       <= sent + CNT_W'(1);
            end
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            occ <= occ + OCC_W'(push) - OCC_W'(pop);

            // Abort drops buffered words; late returns are ignored via push above.
            if (flush_now) begin
                head <= '0;
                tail <= '0;
                occ  <= '0;
            end

            done <= (state_next == DONE);
            busy <= (state_next == ISSUE || state_next == DRAIN || state_next == FLUSH);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            buf_mem[tail] <= readdata;
        end
    end

    overflow_check: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && occ == OCC_W'(BUF_DEPTH)));

endmodule

// File: tb/tb_ukf_input_loader.sv
// Directed bench for ukf_input_loader: a table of transfers checked for address order,
// data order, latency, credit limit and done/busy timing, plus reset and idle-abort checks.
module tb_ukf_input_loader;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic [9:0]   base_addr;
    logic [10:0]  word_count;
    logic         ready_in;
    logic [127:0] readdata = '0;
    logic [9:0]   address;
    logic         chipselect;
    logic         clken;
    logic [15:0]  byteenable;
    logic         write;
    logic         wr_enable;
    logic [127:0] write_data;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    ukf_input_loader dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .word_count (word_count),
        .ready_in   (ready_in),
        .readdata   (readdata),
        .address    (address),
        .chipselect (chipselect),
        .clken      (clken),
        .byteenable (byteenable),
        .write      (write),
        .wr_enable  (wr_enable),
        .write_data (write_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Single-cycle-latency memory whose word n holds the value n.
    always @(posedge clock) begin
        if (chipselect) begin
            readdata <= 128'(address);
        end
    end

    typedef struct {
        logic [9:0] base;
        int count;
        int readyMode;
        int abortCycle;
        int extraStart;
        int expCs;
        int expWr;
        int expFirstCs;
        int expFirstWr;
        int expDone;
        int expBusyLow;
    } vec_t;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic ab, input logic [9:0] b,
                                 input logic [10:0] cnt, input logic rdy);
        start      = st;
        abort      = ab;
        base_addr  = b;
        word_count = cnt;
        ready_in   = rdy;
    endtask

    task automatic runVector(input int idx, input vec_t v);
        int csN = 0, wrN = 0, doneN = 0;
        int firstCs = -1, firstWr = -1, doneCyc = -1, busyLow = -1;
        bit finished = 0;
        logic [9:0] expA;
        for (int c = 0; c < 300 && !finished; c++) begin
            @(negedge clock);
            if (chipselect) begin
                expA = v.base + 10'(csN);
                checkOutput($sformatf("v%0d address[%0d]", idx, csN), 128'(address), 128'(expA));
                csN++;
                if (firstCs < 0) firstCs = c;
                checkOutput($sformatf("v%0d outstanding<=4", idx), 128'(csN - wrN <= 4), 128'(1));
            end
            if (wr_enable) begin
                expA = v.base + 10'(wrN);
                checkOutput($sformatf("v%0d write_data[%0d]", idx, wrN), write_data, 128'(expA));
                wrN++;
                if (firstWr < 0) firstWr = c;
            end
            if (done) begin
                doneN++;
                if (doneCyc < 0) doneCyc = c;
            end
            if (c >= 1 && !busy && busyLow < 0) busyLow = c;

            if (c == 0)
                applyStimulus(1'b1, 1'b0, v.base, 11'(v.count), 1'b1);
            else if (c == v.extraStart)
                applyStimulus(1'b1, 1'b0, 10'h300, 11'd9, 1'b1);
            else
                applyStimulus(1'b0, c == v.abortCycle, 10'h0, 11'd0, 1'b1);
            if (v.readyMode == 1) ready_in = (c % 4 == 0);

            finished = (v.expDone >= 0) ? (doneCyc >= 0) : (busyLow >= 0);
        end
        checkOutput($sformatf("v%0d completed in budget", idx), 128'(finished), 128'(1));
        checkOutput($sformatf("v%0d chipselect count", idx), 128'(csN), 128'(v.expCs));
        checkOutput($sformatf("v%0d wr_enable count", idx), 128'(wrN), 128'(v.expWr));
        checkOutput($sformatf("v%0d first chipselect cycle", idx), 128'(firstCs), 128'(v.expFirstCs));
        checkOutput($sformatf("v%0d first wr_enable cycle", idx), 128'(firstWr), 128'(v.expFirstWr));
        checkOutput($sformatf("v%0d done cycle", idx), 128'(doneCyc), 128'(v.expDone));
        checkOutput($sformatf("v%0d done pulses", idx), 128'(doneN), 128'(v.expDone >= 0 ? 1 : 0));
        checkOutput($sformatf("v%0d busy low cycle", idx), 128'(busyLow), 128'(v.expBusyLow));
    endtask

    vec_t vecs[9];

    initial begin
        //          base    cnt rdy abort extra  cs  wr fCs fWr done busyLow
        vecs[0] = '{10'h010,  8, 0,  -1,  -1,    8,  8,  1,  4, 12, 12};
        vecs[1] = '{10'h3FE,  4, 0,  -1,  -1,    4,  4,  1,  4,  8,  8};
        vecs[2] = '{10'h080, 16, 1,  -1,  -1,   16, 16,  1,  5, 66, 66};
        vecs[3] = '{10'h123,  0, 0,  -1,  -1,    0,  0, -1, -1,  1,  1};
        vecs[4] = '{10'h200, 32, 0,   5,  -1,    5,  2,  1,  4, -1,  8};
        vecs[5] = '{10'h100,  2, 0,  -1,  -1,    2,  2,  1,  4,  6,  6};
        vecs[6] = '{10'h020,  4, 0,  -1,   3,    4,  4,  1,  4,  8,  8};
        vecs[7] = '{10'h040,  2, 0,  -1,   6,    2,  2,  1,  4,  6,  6};
        vecs[8] = '{10'h155,  3, 0,  -1,  -1,    3,  3,  1,  4,  7,  7};

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 10'h0, 11'd0, 1'b1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset address", 128'(address), 128'(0));
        checkOutput("reset chipselect", 128'(chipselect), 128'(0));
        checkOutput("reset wr_enable", 128'(wr_enable), 128'(0));
        checkOutput("reset write_data", write_data, 128'(0));
        checkOutput("reset busy", 128'(busy), 128'(0));
        checkOutput("reset done", 128'(done), 128'(0));
        checkOutput("reset clken", 128'(clken), 128'(1));
        checkOutput("reset byteenable", 128'(byteenable), 128'(16'hFFFF));
        checkOutput("reset write", 128'(write), 128'(0));
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post-reset busy", 128'(busy), 128'(0));
        checkOutput("post-reset chipselect", 128'(chipselect), 128'(0));

        applyStimulus(1'b0, 1'b1, 10'h0, 11'd0, 1'b1);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, 10'h0, 11'd0, 1'b1);
        checkOutput("idle abort busy", 128'(busy), 128'(0));
        checkOutput("idle abort chipselect", 128'(chipselect), 128'(0));

        for (int i = 0; i < 9; i++) begin
            runVector(i, vecs[i]);
        end

        repeat (4) begin
            @(negedge clock);
            applyStimulus(1'b0, 1'b0, 10'h0, 11'd0, 1'b1);
        end
        checkOutput("final idle busy", 128'(busy), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
